video_timing_pattern_generator: RTL and testbench

// - Source end of the pixel stream: generates de/hsync/vsync and RGB on the pixel clock and

---
 rtl/video_timing_pattern_generator.sv | 172 +++++++++++++++++
 tb/tb_video_timing_pattern_generator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern_generator.sv
// Video timing and calibration pattern generator feeding the HDMI encoder path.
// Optional feature: define VTG_BORDER_EN to force a white 1-pixel border around the active area.
module video_timing_pattern_generator #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] pattern_sel,
  input  logic [7:0] level,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic [2:0]    sel_shadow;
  logic [7:0]    level_shadow;

  int            h_p0;
  int            v_p0;
  logic          origin_p0;
  logic          active_p0;
  logic          hs_on_p0;
  logic          vs_on_p0;
  logic [2:0]    sel_p0;
  logic [7:0]    level_p0;
  logic [23:0]   rgb_p0;

  logic          de_p1;
  logic          hs_p1;
  logic          vs_p1;
  logic          fs_p1;
  logic [23:0]   rgb_p1;

  function automatic logic [2:0] bar_index(input int h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h >= (k * H_ACTIVE) / 8) idx = 3'(k);
    end
    return idx;
  endfunction

  // Lit channels as {r,g,b}: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] lit;
    lit = 3'b000;
    case (idx)
      3'd0:    lit = 3'b111;
      3'd1:    lit = 3'b110;
      3'd2:    lit = 3'b011;
      3'd3:    lit = 3'b010;
      3'd4:    lit = 3'b101;
      3'd5:    lit = 3'b100;
      3'd6:    lit = 3'b001;
      default: lit = 3'b000;
    endcase
    return lit;
  endfunction

  function automatic logic [23:0] pattern_pixel(input logic [2:0] sel, input logic [7:0] lvl,
                                                input int h, input int v);
    logic [23:0] px;
    logic [2:0]  lit;
    logic [7:0]  ramp_h;
    logic [7:0]  ramp_v;
    ramp_h = 8'(h);
    ramp_v = 8'(v);
    lit    = 3'b000;
    px     = 24'h0;
    case (sel)
      3'd0: px = {3{lvl}};
      3'd1: begin
        lit = bar_colour(bar_index(h));
        px  = {lit[2] ? lvl : 8'h00, lit[1] ? lvl : 8'h00, lit[0] ? lvl : 8'h00};
      end
      3'd2: px = {3{ramp_h}};
      3'd3: px = {3{ramp_v}};
      3'd4: px = (ramp_h[5] ^ ramp_v[5]) ? {3{lvl}} : 24'h0;
      3'd5: px = {3{ramp_h[7:4], ramp_h[7:4]}};
      default: px = 24'h0;
    endcase
    return px;
  endfunction

  // Stage p0: raster counters; held at origin while idle.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 1'b1;
    end
  end

  // The origin pixel already uses the live inputs, so the whole frame sees one setting.
  always_ff @(posedge clk) begin
    if (origin_p0) begin
      sel_shadow   <= pattern_sel;
      level_shadow <= level;
    end
  end

  always_comb begin
    h_p0      = int'(h_cnt_p0);
    v_p0      = int'(v_cnt_p0);
    origin_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    active_p0 = (h_p0 < H_ACTIVE) && (v_p0 < V_ACTIVE);
    hs_on_p0  = (h_p0 >= H_ACTIVE + H_FP) && (h_p0 < H_ACTIVE + H_FP + H_SYNC);
    vs_on_p0  = (v_p0 >= V_ACTIVE + V_FP) && (v_p0 < V_ACTIVE + V_FP + V_SYNC);
    sel_p0    = origin_p0 ? pattern_sel : sel_shadow;
    level_p0  = origin_p0 ? level : level_shadow;
    rgb_p0    = 24'h0;
    if (active_p0) begin
      rgb_p0 = pattern_pixel(sel_p0, level_p0, h_p0, v_p0);
`ifdef VTG_BORDER_EN
      if ((h_p0 == 0) || (h_p0 == H_ACTIVE - 1) || (v_p0 == 0) || (v_p0 == V_ACTIVE - 1))
        rgb_p0 = 24'hFFFFFF;
`endif
    end
  end

  // Stage p1: registered outputs, one clock after the counter state they decode.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      de_p1  <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
      fs_p1  <= 1'b0;
      rgb_p1 <= 24'h0;
    end else begin
      de_p1  <= active_p0;
      hs_p1  <= hs_on_p0 ~^ SYNC_POL;
      vs_p1  <= vs_on_p0 ~^ SYNC_POL;
      fs_p1  <= origin_p0;
      rgb_p1 <= rgb_p0;
    end
  end

  assign de          = de_p1;
  assign hsync       = hs_p1;
  assign vsync       = vs_p1;
  assign frame_start = fs_p1;
  assign r           = rgb_p1[23:16];
  assign g           = rgb_p1[15:8];
  assign b           = rgb_p1[7:0];

endmodule

// File: tb/tb_video_timing_pattern_generator.sv
// Self-checking bench for video_timing_pattern_generator with a small 14x7 raster.
module tb_video_timing_pattern_generator;

  localparam int   HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;
  localparam logic POL = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] pattern_sel = 3'd0;
  logic [7:0] level = 8'd0;
  logic       de, hsync, vsync, frame_start;
  logic [7:0] r, g, b;

  video_timing_pattern_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel), .level(level),
    .de(de), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  int          t_pos  = 0;
  logic [2:0]  m_sel  = 3'd0;
  logic [7:0]  m_lvl  = 8'd0;
  logic [27:0] exp_bus;
  logic [27:0] obs;
  logic [27:0] idle_bus;

  assign obs      = {de, hsync, vsync, frame_start, r, g, b};
  assign idle_bus = {1'b0, ~POL, ~POL, 1'b0, 24'h0};

  function automatic logic [23:0] model_pixel(input int h, input int v,
                                              input logic [2:0] sel, input logic [7:0] lvl);
    logic [23:0] masks [8];
    logic [23:0] grey;
    logic [23:0] px;
    int          k;
    masks = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    grey  = {3{lvl}};
    k     = 0;
    for (int i = 0; i < 8; i++) if (h >= (i * HA) / 8) k = i;
    case (sel)
      3'd0:    px = grey;
      3'd1:    px = masks[k] & grey;
      3'd2:    px = {3{8'(h % 256)}};
      3'd3:    px = {3{8'(v % 256)}};
      3'd4:    px = ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? grey : 24'h0;
      3'd5:    px = {3{8'(((h % 256) / 16) * 17)}};
      default: px = 24'h0;
    endcase
`ifdef VTG_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) px = 24'hFFFFFF;
`endif
    return px;
  endfunction

  // Advance one clock: predict from the inputs seen at the edge, then settle past it.
  task automatic tick();
    int   h, v;
    logic act, hs_in, vs_in;
    if (reset || !enable) begin
      exp_bus = {1'b0, ~POL, ~POL, 1'b0, 24'h0};
      t_pos   = 0;
    end else begin
      h = t_pos % HT;
      v = t_pos / HT;
      if (t_pos == 0) begin
        m_sel = pattern_sel;
        m_lvl = level;
      end
      act   = (h < HA) && (v < VA);
      hs_in = (h >= HA + HF) && (h < HA + HF + HS);
      vs_in = (v >= VA + VF) && (v < VA + VF + VS);
      exp_bus = {act, hs_in ? POL : ~POL, vs_in ? POL : ~POL, (t_pos == 0),
                 act ? model_pixel(h, v, m_sel, m_lvl) : 24'h0};
      t_pos = (t_pos + 1) % FT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== idle_bus) $display("FAIL reset_idle cyc%0d got %h want %h", i, obs, idle_bus);
      else passed++;
    end
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_timing();
    int fs1, fs2, de_cnt, hs_cnt, vs_cnt, de_rise, hs_rise, vs_rise;
    logic de_prev, hs_prev, vs_prev;
    fs1 = -1; fs2 = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    de_rise = -1; hs_rise = -1; vs_rise = -1;
    de_prev = 1'b0; hs_prev = 1'b0; vs_prev = 1'b0;
    pattern_sel = 3'd0;
    level = 8'($urandom);
    enable = 1'b1;
    for (int i = 1; i <= 2 * FT + 2; i++) begin
      tick();
      total++;
      if (obs !== exp_bus) $display("FAIL timing_model cyc%0d got %h want %h", i, obs, exp_bus);
      else passed++;
      if (frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (i <= FT) begin
        if (de === 1'b1) de_cnt++;
        if (hsync === 1'b1) hs_cnt++;
        if (vsync === 1'b1) vs_cnt++;
        if (de === 1'b1 && !de_prev && de_rise < 0) de_rise = i;
        if (hsync === 1'b1 && !hs_prev && hs_rise < 0) hs_rise = i;
        if (vsync === 1'b1 && !vs_prev && vs_rise < 0) vs_rise = i;
      end
      de_prev = (de === 1'b1); hs_prev = (hsync === 1'b1); vs_prev = (vsync === 1'b1);
    end
    total++; if (fs1 != 1) $display("FAIL fs_first got %0d want 1", fs1); else passed++;
    total++; if (fs2 != 1 + FT) $display("FAIL fs_period got %0d want %0d", fs2, 1 + FT); else passed++;
    total++; if (de_cnt != 32) $display("FAIL de_count got %0d want 32", de_cnt); else passed++;
    total++; if (hs_cnt != 14) $display("FAIL hs_count got %0d want 14", hs_cnt); else passed++;
    total++; if (vs_cnt != 14) $display("FAIL vs_count got %0d want 14", vs_cnt); else passed++;
    total++; if (hs_rise - de_rise != 10) $display("FAIL hs_offset got %0d want 10", hs_rise - de_rise); else passed++;
    total++; if (vs_rise != 71) $display("FAIL vs_line5 got %0d want 71", vs_rise); else passed++;
  endtask

  task automatic test_bars();
    logic [23:0] bars [8];
    bars = '{24'h808080, 24'h808000, 24'h008080, 24'h008000,
             24'h800080, 24'h800000, 24'h000080, 24'h000000};
    enable = 1'b0;
    tick();
    pattern_sel = 3'd1;
    level = 8'h80;
    enable = 1'b1;
    for (int i = 1; i <= FT; i++) begin
      tick();
      total++;
      if (obs !== exp_bus) $display("FAIL bars_model cyc%0d got %h want %h", i, obs, exp_bus);
      else passed++;
`ifndef VTG_BORDER_EN
      if (i >= 2 && i <= 7) begin
        total++;
        if ({r, g, b} !== bars[i-1]) $display("FAIL bar%0d got %h want %h", i - 1, {r, g, b}, bars[i-1]);
        else passed++;
      end
`endif
    end
  endtask

  task automatic test_level_change();
    logic [7:0] l1, l2;
    logic       seen;
    enable = 1'b0;
    tick();
    l1 = 8'($urandom);
    l2 = l1 ^ (8'($urandom) | 8'h01);
    pattern_sel = 3'd0;
    level = l1;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    level = l2;
    seen = 1'b0;
    for (int i = 0; i < FT + 4 && !seen; i++) begin
      tick();
      total++;
      if (obs !== exp_bus) $display("FAIL level_model cyc%0d got %h want %h", i, obs, exp_bus);
      else passed++;
      if (frame_start === 1'b1) begin
        seen = 1'b1;
`ifndef VTG_BORDER_EN
        total++;
        if ({r, g, b} !== {3{l2}}) $display("FAIL level_new got %h want %h", {r, g, b}, {3{l2}});
        else passed++;
`endif
      end
`ifndef VTG_BORDER_EN
      else if (de === 1'b1) begin
        total++;
        if ({r, g, b} !== {3{l1}}) $display("FAIL level_hold got %h want %h", {r, g, b}, {3{l1}});
        else passed++;
      end
`endif
    end
    total++;
    if (!seen) $display("FAIL level_fs_timeout got 0 want 1"); else passed++;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    tick();
    pattern_sel = 3'($urandom);
    level = 8'($urandom);
    enable = 1'b1;
    for (int i = 0; i < HT + 3; i++) tick();
    enable = 1'b0;
    tick();
    total++;
    if (obs !== idle_bus) $display("FAIL drop_idle got %h want %h", obs, idle_bus); else passed++;
    tick();
    enable = 1'b1;
    tick();
    total++;
    if (frame_start !== 1'b1 || de !== 1'b1) $display("FAIL reenable_fs got fs=%b de=%b want 1 1", frame_start, de);
    else passed++;
    total++;
    if (obs !== exp_bus) $display("FAIL reenable_model got %h want %h", obs, exp_bus); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = $urandom_range(20, 60);
    pattern_sel = 3'($urandom);
    level = 8'($urandom);
    enable = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
    tick();
    total++;
    if (obs !== idle_bus) $display("FAIL rstmid_idle got %h want %h", obs, idle_bus); else passed++;
    reset = 1'b0;
    tick();
    total++;
    if (frame_start !== 1'b1) $display("FAIL rstmid_fs got %b want 1", frame_start); else passed++;
    total++;
`ifdef VTG_BORDER_EN
    if ({r, g, b} !== 24'hFFFFFF) $display("FAIL rstmid_border got %h want ffffff", {r, g, b});
`else
    if ({r, g, b} !== model_pixel(0, 0, pattern_sel, level))
      $display("FAIL rstmid_pix got %h want %h", {r, g, b}, model_pixel(0, 0, pattern_sel, level));
`endif
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      enable      = ($urandom_range(0, 199) != 0);
      pattern_sel = 3'($urandom);
      level       = 8'($urandom);
      tick();
      total++;
      if (obs !== exp_bus) $display("FAIL random_model cyc%0d got %h want %h", i, obs, exp_bus);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_bars();
    test_level_change();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
